// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing generator with a pixel-source request port,
// a latency-matched control pipeline, frame-synchronous test patterns and
// registered sync/colour outputs.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned LATENCY  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] R_in,
    input  logic [COLOR_W-1:0] G_in,
    input  logic [COLOR_W-1:0] B_in,
    output logic [10:0]        x,
    output logic [9:0]         y,
    output logic               req,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               de,
    output logic               frame_start,
    output logic               line_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam logic        HS_ON    = 1'(HS_POL);
    localparam logic        VS_ON    = 1'(VS_POL);

    // Per-pixel control word carried alongside the pixel-source latency.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic       ls;
        logic [2:0] bar;
    } ctrl_t;

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [1:0]  mode_reg_q, mode_reg_d;
    logic        req_q, req_d;

    ctrl_t ctrl0;
    ctrl_t tap_ctrl;

    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               de_q, de_d;
    logic               fs_q, fs_d;
    logic               ls_q, ls_d;
    logic [COLOR_W-1:0] r_q, r_d;
    logic [COLOR_W-1:0] g_q, g_d;
    logic [COLOR_W-1:0] b_q, b_d;

    // Raster counters, frame-boundary mode capture and registered request flag.
    always_comb begin
        hcount_d   = hcount_q + 11'd1;
        vcount_d   = vcount_q;
        mode_reg_d = mode_reg_q;
        if (hcount_q == 11'(H_TOTAL - 1)) begin
            hcount_d = '0;
            vcount_d = (vcount_q == 10'(V_TOTAL - 1)) ? '0 : vcount_q + 10'd1;
        end
        if ((hcount_q == '0) && (vcount_q == '0)) begin
            mode_reg_d = mode;
        end
        req_d = (hcount_d < 11'(H_ACTIVE)) && (vcount_d < 10'(V_ACTIVE));
    end

    // Counter state; reset parks the raster on pixel (0,0) in black mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q   <= '0;
            vcount_q   <= '0;
            mode_reg_q <= 2'd2;
            req_q      <= 1'b1;
        end else begin
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            mode_reg_q <= mode_reg_d;
            req_q      <= req_d;
        end
    end

    // Stage-0 controls decoded from the live counters.
    always_comb begin
        ctrl0     = '0;
        ctrl0.hs  = (hcount_q >= 11'(HS_START)) && (hcount_q < 11'(HS_END));
        ctrl0.vs  = (vcount_q >= 10'(VS_START)) && (vcount_q < 10'(VS_END));
        ctrl0.de  = (hcount_q < 11'(H_ACTIVE)) && (vcount_q < 10'(V_ACTIVE));
        ctrl0.fs  = (hcount_q == '0) && (vcount_q == '0);
        ctrl0.ls  = (hcount_q == '0);
        ctrl0.bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (hcount_q >= 11'((k * H_ACTIVE) / 8)) begin
                ctrl0.bar = 3'(k);
            end
        end
    end

    generate
        if (LATENCY == 0) begin : g_nodelay
            assign tap_ctrl = ctrl0;
        end else begin : g_delay
            ctrl_t pipe_q [LATENCY];
            ctrl_t pipe_d [LATENCY];

            // Shift controls one stage per clock to match the pixel source.
            always_comb begin
                pipe_d[0] = ctrl0;
                for (int i = 1; i < int'(LATENCY); i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            // Delay-line registers; reset flushes every stage to inactive.
            always_ff @(posedge clk) begin
                for (int i = 0; i < int'(LATENCY); i++) begin
                    pipe_q[i] <= reset ? ctrl_t'('0) : pipe_d[i];
                end
            end

            assign tap_ctrl = pipe_q[LATENCY-1];
        end
    endgenerate

    // Output-stage colour select and sync polarity.
    always_comb begin
        hsync_d = tap_ctrl.hs ? HS_ON : ~HS_ON;
        vsync_d = tap_ctrl.vs ? VS_ON : ~VS_ON;
        de_d    = tap_ctrl.de;
        fs_d    = tap_ctrl.fs;
        ls_d    = tap_ctrl.ls;
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;
        if (tap_ctrl.de) begin
            case (mode_reg_q)
                2'd0: begin
                    r_d = R_in;
                    g_d = G_in;
                    b_d = B_in;
                end
                2'd1: begin
                    // Bar order white..black maps to inverted index bits.
                    r_d = {COLOR_W{~tap_ctrl.bar[1]}};
                    g_d = {COLOR_W{~tap_ctrl.bar[2]}};
                    b_d = {COLOR_W{~tap_ctrl.bar[0]}};
                end
                default: begin
                    r_d = '0;
                    g_d = '0;
                    b_d = '0;
                end
            endcase
        end
    end

    // Output registers; reset drives idle levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= ~HS_ON;
            vsync_q <= ~VS_ON;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign x           = hcount_q;
    assign y           = vcount_q;
    assign req         = req_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (LATENCY 1 active-low syncs,
// LATENCY 2 active-high syncs) on a reduced raster, checked every cycle
// against an arithmetic raster model plus table and hand-written sequences.
module tb_vga_timing_gen;

    localparam int HA = 20, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int LAT_A = 1;
    localparam int LAT_B = 2;
    // Colour bar palette as {R,G,B} bits: white, yellow, cyan, green, magenta, red, blue, black.
    localparam int BAR_RGB [8] = '{7, 6, 3, 2, 5, 4, 1, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic [1:0] mode  = 2'd0;

    logic [3:0]  ra_in, ga_in, ba_in, rb_in, gb_in, bb_in;
    logic [10:0] x_a, x_b;
    logic [9:0]  y_a, y_b;
    logic        req_a, req_b, hsync_a, hsync_b, vsync_a, vsync_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        de_a, de_b, fs_a, fs_b, ls_a, ls_b;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(0), .VS_POL(0), .COLOR_W(4), .LATENCY(LAT_A)
    ) dut_a (
        .clk(clk), .reset(reset), .mode(mode),
        .R_in(ra_in), .G_in(ga_in), .B_in(ba_in),
        .x(x_a), .y(y_a), .req(req_a), .hsync(hsync_a), .vsync(vsync_a),
        .R(r_a), .G(g_a), .B(b_a), .de(de_a),
        .frame_start(fs_a), .line_start(ls_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1), .VS_POL(1), .COLOR_W(4), .LATENCY(LAT_B)
    ) dut_b (
        .clk(clk), .reset(reset), .mode(mode),
        .R_in(rb_in), .G_in(gb_in), .B_in(bb_in),
        .x(x_b), .y(y_b), .req(req_b), .hsync(hsync_b), .vsync(vsync_b),
        .R(r_b), .G(g_b), .B(b_b), .de(de_b),
        .frame_start(fs_b), .line_start(ls_b)
    );

    // Pixel sources: a random colour per raster position, one (A) or two (B) registers deep.
    logic [11:0] lut [FRAME];
    logic [11:0] src_a_q, src_b1_q, src_b2_q;
    always @(posedge clk) begin
        src_a_q  <= lut[int'(y_a) * HT + int'(x_a)];
        src_b1_q <= {x_b[3:0], lut[int'(y_b) * HT + int'(x_b)][7:0]};
        src_b2_q <= src_b1_q;
    end
    assign ra_in = src_a_q[11:8];
    assign ga_in = src_a_q[7:4];
    assign ba_in = src_a_q[3:0];
    assign rb_in = src_b2_q[11:8];
    assign gb_in = src_b2_q[7:4];
    assign bb_in = src_b2_q[3:0];

    int asserts = 0;
    int fails   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // Reference: n = clock edges since the last reset edge; frame_mode = mode seen at each frame start.
    int  n = 0;
    bit  started = 1'b0;
    int  frame_mode [int];
    always @(posedge clk) begin
        if (reset) begin
            n = 0;
            frame_mode.delete();
            started = 1'b1;
        end else begin
            if (n % FRAME == 0) frame_mode[n / FRAME] = int'(mode);
            n = n + 1;
        end
    end

    function automatic int bar_of(input int xx);
        for (int k = 0; k < 8; k++) begin
            if (xx >= k * HA / 8 && xx < (k + 1) * HA / 8) return k;
        end
        return 7;
    endfunction

    // Expected pin vector {hsync, vsync, de, fs, ls, R, G, B} after edge nn.
    function automatic logic [16:0] model_pins(input int nn, input int lat, input bit pol, input bit r_from_x);
        int q, p, hc, vc, m, k;
        logic hs, vs, dd, fs, ls;
        logic [3:0] r, g, b;
        hs = 0; vs = 0; dd = 0; fs = 0; ls = 0; r = 0; g = 0; b = 0;
        q = nn - lat - 1;
        if (q >= 0) begin
            p  = q % FRAME;
            hc = p % HT;
            vc = p / HT;
            hs = (hc >= HA + HFP) && (hc < HA + HFP + HSY);
            vs = (vc >= VA + VFP) && (vc < VA + VFP + VSY);
            dd = (hc < HA) && (vc < VA);
            fs = (p == 0);
            ls = (hc == 0);
            if (dd) begin
                m = frame_mode.exists(q / FRAME) ? frame_mode[q / FRAME] : 2;
                if (m == 0) begin
                    r = r_from_x ? 4'(hc % 16) : lut[p][11:8];
                    g = lut[p][7:4];
                    b = lut[p][3:0];
                end else if (m == 1) begin
                    k = BAR_RGB[bar_of(hc)];
                    r = ((k & 4) != 0) ? 4'hF : 4'h0;
                    g = ((k & 2) != 0) ? 4'hF : 4'h0;
                    b = ((k & 1) != 0) ? 4'hF : 4'h0;
                end
            end
        end
        return {pol ? hs : ~hs, pol ? vs : ~vs, dd, fs, ls, r, g, b};
    endfunction

    function automatic logic [21:0] model_xy(input int nn);
        int hc, vc;
        hc = nn % HT;
        vc = (nn / HT) % VT;
        return {11'(hc), 10'(vc), 1'((hc < HA) && (vc < VA))};
    endfunction

    // Continuous cycle-by-cycle comparison of both instances.
    always @(negedge clk) begin
        if (started) begin
            check("pins_a", {hsync_a, vsync_a, de_a, fs_a, ls_a, r_a, g_a, b_a}, model_pins(n, LAT_A, 1'b0, 1'b0));
            check("pins_b", {hsync_b, vsync_b, de_b, fs_b, ls_b, r_b, g_b, b_b}, model_pins(n, LAT_B, 1'b1, 1'b1));
            check("xy_a", {x_a, y_a, req_a}, model_xy(n));
            check("xy_b", {x_b, y_b, req_b}, model_xy(n));
        end
    end

    // Wait (bounded) for the negedge where (n - off) lands on raster position target.
    task automatic wait_pos(input string name, input int off, input int target);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 2 * FRAME + 8 && !ok; c++) begin
            @(negedge clk);
            if (n - off >= 0 && (n - off) % FRAME == target) ok = 1'b1;
        end
        if (!ok) begin
            asserts++;
            fails++;
            $display("FAIL %s timeout: position %0d not reached", name, target);
        end
    endtask

    // Count sync/de/strobe activity over any full-frame window.
    task automatic frame_stats(input string tag);
        int de_ca, hs_ca, vs_ca, fs_ca, ls_ca, de_cb, hs_cb, vs_cb, fs_cb, ls_cb;
        de_ca = 0; hs_ca = 0; vs_ca = 0; fs_ca = 0; ls_ca = 0;
        de_cb = 0; hs_cb = 0; vs_cb = 0; fs_cb = 0; ls_cb = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            de_ca += int'(de_a); hs_ca += int'(!hsync_a); vs_ca += int'(!vsync_a);
            fs_ca += int'(fs_a); ls_ca += int'(ls_a);
            de_cb += int'(de_b); hs_cb += int'(hsync_b); vs_cb += int'(vsync_b);
            fs_cb += int'(fs_b); ls_cb += int'(ls_b);
        end
        check({tag, "_de_a"}, de_ca, HA * VA);
        check({tag, "_hs_a"}, hs_ca, HSY * VT);
        check({tag, "_vs_a"}, vs_ca, VSY * HT);
        check({tag, "_fs_a"}, fs_ca, 1);
        check({tag, "_ls_a"}, ls_ca, VT);
        check({tag, "_de_b"}, de_cb, HA * VA);
        check({tag, "_hs_b"}, hs_cb, HSY * VT);
        check({tag, "_vs_b"}, vs_cb, VSY * HT);
        check({tag, "_fs_b"}, fs_cb, 1);
        check({tag, "_ls_b"}, ls_cb, VT);
    endtask

    typedef struct {
        int         xx;
        logic       de;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } bar_vec_t;

    bar_vec_t bars [16];

    initial begin
        // Bar boundaries for a 20-pixel line: 0,2,5,7,10,12,15,17,20.
        bars[0]  = '{0,  1'b1, 4'hF, 4'hF, 4'hF};
        bars[1]  = '{1,  1'b1, 4'hF, 4'hF, 4'hF};
        bars[2]  = '{2,  1'b1, 4'hF, 4'hF, 4'h0};
        bars[3]  = '{4,  1'b1, 4'hF, 4'hF, 4'h0};
        bars[4]  = '{5,  1'b1, 4'h0, 4'hF, 4'hF};
        bars[5]  = '{6,  1'b1, 4'h0, 4'hF, 4'hF};
        bars[6]  = '{7,  1'b1, 4'h0, 4'hF, 4'h0};
        bars[7]  = '{9,  1'b1, 4'h0, 4'hF, 4'h0};
        bars[8]  = '{10, 1'b1, 4'hF, 4'h0, 4'hF};
        bars[9]  = '{12, 1'b1, 4'hF, 4'h0, 4'h0};
        bars[10] = '{14, 1'b1, 4'hF, 4'h0, 4'h0};
        bars[11] = '{15, 1'b1, 4'h0, 4'h0, 4'hF};
        bars[12] = '{16, 1'b1, 4'h0, 4'h0, 4'hF};
        bars[13] = '{17, 1'b1, 4'h0, 4'h0, 4'h0};
        bars[14] = '{19, 1'b1, 4'h0, 4'h0, 4'h0};
        bars[15] = '{20, 1'b0, 4'h0, 4'h0, 4'h0};

        for (int i = 0; i < FRAME; i++) lut[i] = 12'($urandom);

        // Reset state.
        reset = 1'b1;
        mode  = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_idle_a", {hsync_a, vsync_a, de_a, fs_a, ls_a, r_a, g_a, b_a}, {2'b11, 15'd0});
        check("rst_idle_b", {hsync_b, vsync_b, de_b, fs_b, ls_b, r_b, g_b, b_b}, {2'b00, 15'd0});
        check("rst_xy", {x_a, y_a, req_a}, {11'd0, 10'd0, 1'b1});
        reset = 1'b0;

        // Pass-through frames and per-frame timing totals.
        repeat (FRAME + 10) @(negedge clk);
        frame_stats("m0");

        // Colour bars on output row 2 of both instances.
        mode = 2'd1;
        repeat (FRAME + 5) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            wait_pos("bar_wait_a", LAT_A + 1, 2 * HT + bars[i].xx);
            check($sformatf("bar_a_x%0d", bars[i].xx), {de_a, r_a, g_a, b_a},
                  {bars[i].de, bars[i].r, bars[i].g, bars[i].b});
            wait_pos("bar_wait_b", LAT_B + 1, 2 * HT + bars[i].xx);
            check($sformatf("bar_b_x%0d", bars[i].xx), {de_b, r_b, g_b, b_b},
                  {bars[i].de, bars[i].r, bars[i].g, bars[i].b});
        end

        // Mid-frame switch to black takes effect only from the next frame.
        mode = 2'd0;
        repeat (FRAME + 5) @(negedge clk);
        wait_pos("toggle_row", 0, 5 * HT);
        mode = 2'd2;
        wait_pos("next_frame_a", LAT_A + 1, 0);
        begin
            int nz, fsc, dec;
            nz = 0; fsc = 0; dec = 0;
            for (int c = 0; c < FRAME; c++) begin
                nz  += int'((r_a | g_a | b_a) != 4'h0);
                fsc += int'(fs_a);
                dec += int'(de_a);
                @(negedge clk);
            end
            check("black_nonzero", nz, 0);
            check("black_fs_count", fsc, 1);
            check("black_de_count", dec, HA * VA);
        end

        // Reset mid-frame for 3 clocks, then frame_start after LATENCY+1 edges.
        mode = 2'd0;
        wait_pos("reset_row", 0, 6 * HT + 4);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_idle_a", {hsync_a, vsync_a, de_a, fs_a, ls_a, r_a, g_a, b_a}, {2'b11, 15'd0});
        check("midrst_idle_b", {hsync_b, vsync_b, de_b, fs_b, ls_b, r_b, g_b, b_b}, {2'b00, 15'd0});
        check("midrst_xy", {x_b, y_b, req_b}, {11'd0, 10'd0, 1'b1});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("rel_fs_a_%0d", k), fs_a, (k == LAT_A + 1) ? 1 : 0);
            check($sformatf("rel_fs_b_%0d", k), fs_b, (k == LAT_B + 1) ? 1 : 0);
            if (k == 1) check("rel_xy", {x_a, y_a}, {11'd1, 10'd0});
        end

        // Randomised mode changes and occasional short resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1499) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset = 1'b0;
            end
        end
        repeat (FRAME) @(negedge clk);
        frame_stats("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (%0d failures so far)", fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the lab's fixed 640x480 VGA controller.
- Generates hsync/vsync from programmable timing and publishes the current raster coordinate (x, y) to a pixel source.
- Accepts that source's colour LATENCY cycles later and drives registered, sync-aligned RGB with blanking.
- Adds a frame-synchronous test-pattern mode (colour bars / forced black) and frame/line start strobes for game logic (snake, score overlays).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level
COLOR_W, 4, bits per colour channel
LATENCY, 1, pixel-source latency in clocks, legal 0..3

Ports:
clk  in  1  pixel clock (25 MHz for defaults)
reset  in  1  synchronous, active-high
mode  in  2  0 = pass-through, 1 = colour bars, 2/3 = black
R_in  in  COLOR_W  red from pixel source
G_in  in  COLOR_W  green from pixel source
B_in  in  COLOR_W  blue from pixel source
x  out  11  current horizontal counter value (request coordinate)
y  out  10  current vertical counter value
req  out  1  high when (x, y) is in the active area
hsync  out  1  horizontal sync, registered
vsync  out  1  vertical sync, registered
R  out  COLOR_W  red output, 0 when blanked
G  out  COLOR_W  green output, 0 when blanked
B  out  COLOR_W  blue output, 0 when blanked
de  out  1  output data-enable, aligned with R/G/B
frame_start  out  1  one-cycle pulse, output-aligned pixel (0,0)
line_start  out  1  one-cycle pulse, output-aligned x = 0 of every line, blank lines included

Behaviour:
- Derived totals: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Defaults give 800 and 525.
- Counters:
  - hcount increments each clk and wraps H_TOTAL-1 -> 0.
  - vcount increments on each hcount wrap and wraps V_TOTAL-1 -> 0 (frame wrap).
  - x = hcount and y = vcount, driven directly from the registers.
  - req = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- Sync windows, at stage 0:
  - hs0 asserted for H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1 (656..751 at defaults).
  - vs0 asserted for V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1 (490..491 at defaults).
  - Asserted level is HS_POL / VS_POL.
- Pipeline:
  - hs0, vs0, req, pixel-(0,0) flag, x=0 flag and bar index travel through a LATENCY-deep delay line.
  - At stage LATENCY, R_in/G_in/B_in are sampled together with the delayed controls.
  - The output register stage (LATENCY+1) drives hsync, vsync, R/G/B, de, frame_start and line_start.
  - Total latency from counter value to pins is LATENCY+1 clocks. Syncs and colour are always mutually aligned.
- Colour select at the output stage:
  - de = 0: R/G/B = 0.
  - mode 0: R/G/B = sampled inputs.
  - mode 1: 8 vertical bars. Bar k spans x in [k*H_ACTIVE/8, (k+1)*H_ACTIVE/8). Order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or 0.
  - mode 2/3: R/G/B = 0.
- Mode latching:
  - mode is captured into an internal register only when hcount = 0 and vcount = 0.
  - Changes mid-frame take effect from the next frame (no tearing).
  - Reset loads mode_reg = 2 (black) until the first frame boundary capture.
- Reset (synchronous, active-high), while asserted:
  - hcount = vcount = 0 and mode_reg = 2.
  - All delay-line stages are cleared to inactive: de = 0, pulses = 0, syncs deasserted.
  - Outputs: hsync = ~HS_POL, vsync = ~VS_POL, R = G = B = 0, de = frame_start = line_start = 0.
  - x = y = 0; req = 1 (pixel (0,0) is active).
- After reset release:
  - The first clk edge with reset low advances hcount to 1 and samples mode into mode_reg.
  - The (0,0) pixel appears at the outputs with frame_start = 1 on the LATENCY+1-th edge after the last reset edge.
  - Reset mid-frame aborts the frame immediately; there is no partial-line completion.
- Boundaries:
  - x = H_ACTIVE-1 is the last de pixel; x = H_ACTIVE is blank.
  - y = V_ACTIVE-1 is the last active line.
  - At the frame wrap (hcount = H_TOTAL-1, vcount = V_TOTAL-1), both counters go to 0 on the same edge.
  - LATENCY = 0: R_in is sampled in the same cycle x/y are presented, so the source must be combinational.

Test Plan:
- Defaults, mode 0, R_in=G_in=B_in=4'hF, run 2 frames -> hsync low exactly 96 clocks per 800; vsync low exactly 2 lines (1600 clocks) per 525 lines; 640x480 de pixels per frame.
- LATENCY=2, R_in driven as x[3:0] registered twice -> R at output equals the x of the pixel whose de is high (no skew); first output pixel R=0, then 1..15 repeating.
- mode=1 -> at the output, pixels 0..79 are F/F/F, 80..159 are F/F/0 (yellow), 560..639 are 0/0/0; x=640 gives R=G=B=0.
- Toggle mode 0->2 at y=200 -> remainder of the frame unchanged; the next frame is all black; frame_start pulses once per 420000 clocks.
- Assert reset for 3 clocks at y=300 -> outputs go to the idle values on the first reset edge; after release, frame_start occurs LATENCY+1 clocks later; x and y restart from 0.
- HS_POL=1, VS_POL=1 -> sync pulses active-high and idle low during reset; timing identical to the first scenario.
